// File: rtl/cp0_nested_exc.sv
// cp0_nested_exc: coprocessor-0 register block with Count/Compare timer,
// NUM_IRQ maskable external interrupt lines and a hardware save stack of
// {Status,EPC} pairs so that exceptions may nest up to STACK_DEPTH levels.
//
// Interface note: there is no valid/ready handshake here. mfc0, mtc0, eret
// and exception are single-cycle strobes that the pipeline asserts for
// exactly the cycle it wants the action. Per cycle, exception beats eret
// and eret beats mtc0. A lower-priority strobe that loses is dropped, not
// deferred.
module cp0_nested_exc #(
  parameter int          NUM_IRQ     = 6,
  parameter int          STACK_DEPTH = 4,
  parameter logic [31:0] EXC_VECTOR  = 32'h0040_0004
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [31:0]                        pc,
  input  logic                               mfc0,
  input  logic                               mtc0,
  input  logic                               eret,
  input  logic                               exception,
  input  logic [31:0]                        wdata,
  input  logic [4:0]                         addr,
  input  logic [4:0]                         cause,
  input  logic [NUM_IRQ-1:0]                 irq_in,
  output logic [31:0]                        rdata,
  output logic [31:0]                        status,
  output logic [31:0]                        exception_addr,
  output logic                               irq_req,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   nest_depth
);

  localparam int DW = $clog2(STACK_DEPTH+1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  // Writable Status bits: IE, EXL and the IM field (external lines plus timer).
  localparam logic [31:0] STATUS_MASK =
    32'h0000_0003 | (((32'h1 << (NUM_IRQ+1)) - 32'h1) << 8);

  logic [31:0]        count;
  logic [31:0]        compare;
  logic [31:0]        status_r;
  logic [31:0]        epc;
  logic [4:0]         exc_code;
  logic [NUM_IRQ-1:0] ip_ext;
  logic               ti;
  logic               ovf;
  logic [DW-1:0]      depth;

  logic [31:0] stk_status [STACK_DEPTH];
  logic [31:0] stk_epc    [STACK_DEPTH];

  logic [31:0] top_status;
  logic [31:0] top_epc;
  logic [31:0] cause_val;
  logic        stack_full;
  logic        mtc0_eff;
  logic [NUM_IRQ:0] ip_all;
  logic [NUM_IRQ:0] im;

  assign stack_full = (depth == DEPTH_MAX);
  // mtc0 only lands when neither exception nor eret claims the cycle.
  assign mtc0_eff   = mtc0 & ~exception & ~eret;
  assign ip_all     = {ti, ip_ext};
  assign im         = status_r[8 +: NUM_IRQ+1];

  // Select the most recently pushed stack entry (index depth-1).
  always_comb begin
    top_status = '0;
    top_epc    = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (DW'(i + 1) == depth) begin
        top_status = stk_status[i];
        top_epc    = stk_epc[i];
      end
    end
  end

  // Assemble the architectural Cause view from its individual fields.
  always_comb begin
    cause_val                 = '0;
    cause_val[6:2]            = exc_code;
    cause_val[8 +: NUM_IRQ]   = ip_ext;
    cause_val[8 + NUM_IRQ]    = ti;
    cause_val[30]             = ovf;
  end

  // mfc0 read mux; unmapped indices and idle cycles return zero.
  always_comb begin
    rdata = '0;
    if (mfc0) begin
      case (addr)
        REG_COUNT:   rdata = count;
        REG_COMPARE: rdata = compare;
        REG_STATUS:  rdata = status_r;
        REG_CAUSE:   rdata = cause_val;
        REG_EPC:     rdata = epc;
        default:     rdata = '0;
      endcase
    end
  end

  assign status         = status_r;
  assign exception_addr = eret ? epc : EXC_VECTOR;
  assign irq_req        = status_r[0] & ~status_r[1] & (|(ip_all & im));
  assign nest_depth     = depth;

  // Timer, interrupt sampling and the exception/eret/mtc0 register updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      compare  <= '0;
      status_r <= '0;
      epc      <= '0;
      exc_code <= '0;
      ip_ext   <= '0;
      ti       <= 1'b0;
      ovf      <= 1'b0;
      depth    <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stk_status[i] <= '0;
        stk_epc[i]    <= '0;
      end
    end else begin
      ip_ext <= irq_in;

      // Count free-runs; an effective mtc0 Count replaces that cycle's increment.
      if (mtc0_eff && addr == REG_COUNT) count <= wdata;
      else                               count <= count + 32'd1;

      // TI is sticky; only a write to Compare clears it. Compare==0 disables the match.
      if (mtc0_eff && addr == REG_COMPARE)        ti <= 1'b0;
      else if (count == compare && compare != '0) ti <= 1'b1;

      if (exception) begin
        if (stack_full) begin
          // Drop the oldest entry (index 0) and push at the top.
          for (int i = 0; i < STACK_DEPTH-1; i++) begin
            stk_status[i] <= stk_status[i+1];
            stk_epc[i]    <= stk_epc[i+1];
          end
          stk_status[STACK_DEPTH-1] <= status_r;
          stk_epc[STACK_DEPTH-1]    <= epc;
          ovf <= 1'b1;
        end else begin
          for (int i = 0; i < STACK_DEPTH; i++) begin
            if (DW'(i) == depth) begin
              stk_status[i] <= status_r;
              stk_epc[i]    <= epc;
            end
          end
          depth <= depth + DW'(1);
        end
        epc      <= pc;
        exc_code <= cause;
        status_r <= (status_r & ~32'h1) | 32'h2;
      end else if (eret) begin
        if (depth != '0) begin
          status_r <= top_status;
          epc      <= top_epc;
          depth    <= depth - DW'(1);
        end else begin
          status_r <= (status_r & ~32'h2) | 32'h1;
        end
      end else if (mtc0) begin
        case (addr)
          REG_COMPARE: compare  <= wdata;
          REG_STATUS:  status_r <= wdata & STATUS_MASK;
          REG_CAUSE:   ovf      <= wdata[30];
          REG_EPC:     epc      <= wdata;
          default:     ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_nested_exc.sv
// Directed testbench for cp0_nested_exc (NUM_IRQ=6, STACK_DEPTH=4).
// Expected values are hand-computed constants.
module tb_cp0_nested_exc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        mfc0, mtc0, eret, exception;
  logic [31:0] wdata;
  logic [4:0]  addr;
  logic [4:0]  cause;
  logic [5:0]  irq_in;
  logic [31:0] rdata, status, exception_addr;
  logic        irq_req;
  logic [2:0]  nest_depth;

  int checks = 0;
  int errors = 0;

  cp0_nested_exc #(.NUM_IRQ(6), .STACK_DEPTH(4), .EXC_VECTOR(32'h0040_0004)) dut (
    .clk(clk), .rst(rst), .pc(pc), .mfc0(mfc0), .mtc0(mtc0), .eret(eret),
    .exception(exception), .wdata(wdata), .addr(addr), .cause(cause),
    .irq_in(irq_in), .rdata(rdata), .status(status),
    .exception_addr(exception_addr), .irq_req(irq_req), .nest_depth(nest_depth)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    mtc0 = 1'b1; addr = a; wdata = d;
    step();
    mtc0 = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    mfc0 = 1'b1; addr = a;
    #1;
    chk(tag, rdata, exp);
    mfc0 = 1'b0;
    #1;
  endtask

  task automatic exc(input logic [31:0] p, input logic [4:0] c);
    exception = 1'b1; pc = p; cause = c;
    step();
    exception = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    step();
    eret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc = '0; mfc0 = 0; mtc0 = 0; eret = 0; exception = 0;
    wdata = '0; addr = '0; cause = '0; irq_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_status", status, 32'h0);
    chk("rst_depth", 32'(nest_depth), 32'h0);
    chk("rst_irq_req", 32'(irq_req), 32'h0);
    chk("rst_rdata_idle", rdata, 32'h0);
    chk("rst_exc_vector", exception_addr, 32'h0040_0004);
    rd_chk("rst_cause", 5'd13, 32'h0);
    rd_chk("count0", 5'd9, 32'd0);
    step();
    rd_chk("count1", 5'd9, 32'd1);
    step();
    rd_chk("count2", 5'd9, 32'd2);
    rd_chk("unmapped_read", 5'd3, 32'h0);

    // Read in the same cycle as a write returns the old value
    mtc0 = 1'b1; mfc0 = 1'b1; addr = 5'd11; wdata = 32'd5;
    #1;
    chk("rw_same_cycle_old", rdata, 32'h0);
    step();
    mtc0 = 1'b0; mfc0 = 1'b0;
    rd_chk("rw_next_cycle_new", 5'd11, 32'd5);

    // Timer: Compare=20, Count=0, IE=1 with all IM bits
    wr(5'd11, 32'd20);
    wr(5'd9, 32'd0);
    rd_chk("count_loaded", 5'd9, 32'd0);
    wr(5'd12, 32'h0000_7F01);
    repeat (19) step();
    rd_chk("count20", 5'd9, 32'd20);
    rd_chk("ti_not_yet", 5'd13, 32'h0);
    chk("irq_before_ti", 32'(irq_req), 32'h0);
    step();
    rd_chk("count21", 5'd9, 32'd21);
    rd_chk("ti_set", 5'd13, 32'h0000_4000);
    chk("irq_on_ti", 32'(irq_req), 32'h1);
    step();
    rd_chk("ti_sticky", 5'd13, 32'h0000_4000);
    wr(5'd11, 32'd0);
    rd_chk("ti_cleared", 5'd13, 32'h0);
    chk("irq_after_clear", 32'(irq_req), 32'h0);

    // External line 2 masked, then unmasked
    irq_in = 6'b000100;
    wr(5'd12, 32'h0000_7B01);
    rd_chk("ip2_pending", 5'd13, 32'h0000_0400);
    chk("ip2_masked", 32'(irq_req), 32'h0);
    wr(5'd12, 32'h0000_7F01);
    chk("ip2_unmasked", 32'(irq_req), 32'h1);
    irq_in = 6'b000000;
    step();
    rd_chk("ip2_dropped", 5'd13, 32'h0);
    chk("irq_dropped", 32'(irq_req), 32'h0);

    // Status write mask
    wr(5'd12, 32'hFFFF_FFFF);
    chk("status_mask", status, 32'h0000_7F03);
    wr(5'd12, 32'h0000_0001);

    // Two nested exceptions and returns
    exc(32'h100, 5'd8);
    chk("exc1_depth", 32'(nest_depth), 32'd1);
    chk("exc1_status", status, 32'h2);
    rd_chk("exc1_epc", 5'd14, 32'h100);
    rd_chk("exc1_cause", 5'd13, 32'h20);
    exc(32'h200, 5'd4);
    chk("exc2_depth", 32'(nest_depth), 32'd2);
    rd_chk("exc2_epc", 5'd14, 32'h200);
    rd_chk("exc2_cause", 5'd13, 32'h10);
    eret = 1'b1;
    #1;
    chk("eret_addr", exception_addr, 32'h200);
    step();
    eret = 1'b0;
    chk("eret1_depth", 32'(nest_depth), 32'd1);
    rd_chk("eret1_epc", 5'd14, 32'h100);
    chk("eret1_status", status, 32'h2);
    do_eret();
    chk("eret2_depth", 32'(nest_depth), 32'd0);
    chk("eret2_status", status, 32'h1);
    rd_chk("eret2_epc", 5'd14, 32'h0);

    // Overflow: five nested exceptions into a four-deep stack
    for (int k = 1; k <= 5; k++) exc(32'(k * 16), 5'd12);
    chk("ovf_depth", 32'(nest_depth), 32'd4);
    rd_chk("ovf_cause", 5'd13, 32'h4000_0030);
    rd_chk("ovf_epc", 5'd14, 32'h50);
    wr(5'd13, 32'h0);
    rd_chk("ovf_cleared", 5'd13, 32'h0000_0030);
    repeat (4) do_eret();
    chk("ovf_pop_depth", 32'(nest_depth), 32'd0);
    rd_chk("ovf_oldest_dropped", 5'd14, 32'h10);
    chk("ovf_pop_status", status, 32'h2);

    // exception + eret + mtc0 in one cycle: only the exception lands
    exception = 1'b1; eret = 1'b1; mtc0 = 1'b1;
    pc = 32'h300; cause = 5'd5; addr = 5'd12; wdata = 32'h0000_7F01;
    step();
    exception = 1'b0; eret = 1'b0; mtc0 = 1'b0;
    chk("prio_depth", 32'(nest_depth), 32'd1);
    chk("prio_status", status, 32'h2);
    rd_chk("prio_epc", 5'd14, 32'h300);
    rd_chk("prio_cause", 5'd13, 32'h14);
    do_eret();
    rd_chk("prio_pop_epc", 5'd14, 32'h10);
    do_eret();
    chk("eret_d0_status", status, 32'h1);
    chk("eret_d0_depth", 32'(nest_depth), 32'd0);
    rd_chk("eret_d0_epc", 5'd14, 32'h10);

    // Reset while nested
    exc(32'h400, 5'd1);
    exc(32'h500, 5'd2);
    chk("pre_rst_depth", 32'(nest_depth), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_depth", 32'(nest_depth), 32'd0);
    chk("mid_rst_status", status, 32'h0);
    rd_chk("mid_rst_epc", 5'd14, 32'h0);
    rd_chk("mid_rst_count", 5'd9, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
